// File: rtl/axi4_slave_mem_pkg.sv
// Shared types and helpers for the AXI4 slave memory.
//   burst_t   : AXI burst encodings (FIXED/INCR/WRAP/RSVD)
//   resp_t    : AXI response encodings used by this slave (OKAY/SLVERR)
//   w_state_t : write engine states
//   r_state_t : read engine states
//   wrap_mask : byte mask of the wrap window for a given len/bus width
//   burst_cfg_err : flags burst/len combinations this slave rejects
package axi4_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    // Wrap window size in bytes minus one: (len+1)*data_bytes - 1.
    function automatic logic [31:0] wrap_mask(input logic [7:0] len,
                                              input int unsigned data_bytes);
        logic [31:0] span;
        span = ({24'd0, len} + 32'd1) * data_bytes;
        return span - 32'd1;
    endfunction

    // Reserved burst type, or WRAP with a length other than 2/4/8/16 beats.
    function automatic logic burst_cfg_err(input logic [7:0] len,
                                           input logic [1:0] burst);
        logic err;
        err = 1'b0;
        if (burst == BURST_RSVD) begin
            err = 1'b1;
        end else if (burst == BURST_WRAP) begin
            err = !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        end
        return err;
    endfunction

endpackage

// File: rtl/axi4_slave_mem_burst_addr_gen.sv
// Combinational AXI burst address stepper.
//   addr      : address of the current beat
//   count     : index of the current beat (0-based)
//   len       : beats-1 of the burst
//   burst     : burst type
//   next_addr : address of the following beat
//   last      : current beat is the final one (count == len)
//   err       : burst/len combination is unsupported; stepping falls back to INCR
module axi4_burst_addr_gen #(
    parameter int ADDR_W     = 32,
    parameter int DATA_BYTES = 4
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        count,
    input  logic [7:0]        len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr,
    output logic              last,
    output logic              err
);
    import axi4_pkg::*;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_BYTES);

    logic [ADDR_W-1:0] incr_addr;
    logic [ADDR_W-1:0] mask;

    assign incr_addr = addr + STEP;
    assign mask      = ADDR_W'(wrap_mask(len, DATA_BYTES));

    always_comb begin
        err       = burst_cfg_err(len, burst);
        last      = (count == len);
        next_addr = incr_addr;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP: begin
                // Keep the window base, let only the in-window offset advance.
                if (!err) begin
                    next_addr = (addr & ~mask) | (incr_addr & mask);
                end
            end
            default: next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi4_slave_mem.sv
// Synthesizable AXI4 slave memory with independent read and write engines,
// one outstanding transaction per direction.
//   aclk/aresetn     : clock, asynchronous active-low reset
//   aw*              : write address channel (addr, id, len, burst)
//   w*               : write data channel (data, byte strobes, last)
//   b*               : write response channel (resp, echoed id)
//   ar*              : read address channel (addr, id, len, burst)
//   r*               : read data channel (data, resp, echoed id, last)
// Handshake: a transfer happens on a rising edge where valid && ready;
// the sender holds payload stable while valid is high and ready is low.
// Out-of-range beats are not written / read as zero and report SLVERR.
module axi4_slave_mem #(
    parameter int DATA_BYTES  = 4,
    parameter int ADDR_BYTES  = 4,
    parameter int NUM_ID_BITS = 4,
    parameter int MEM_WORDS   = 1024
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ADDR_BYTES*8-1:0] awaddr,
    input  logic [NUM_ID_BITS-1:0]  awid,
    input  logic [7:0]              awlen,
    input  logic [1:0]              awburst,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DATA_BYTES*8-1:0] wdata,
    input  logic [DATA_BYTES-1:0]   wstrb,
    input  logic                    wlast,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [1:0]              bresp,
    output logic [NUM_ID_BITS-1:0]  bid,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [ADDR_BYTES*8-1:0] araddr,
    input  logic [NUM_ID_BITS-1:0]  arid,
    input  logic [7:0]              arlen,
    input  logic [1:0]              arburst,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [DATA_BYTES*8-1:0] rdata,
    output logic [1:0]              rresp,
    output logic [NUM_ID_BITS-1:0]  rid,
    output logic                    rlast
);
    import axi4_pkg::*;

    localparam int ADDR_W = ADDR_BYTES * 8;
    localparam int DATA_W = DATA_BYTES * 8;
    localparam int OFFS_W = $clog2(DATA_BYTES);
    localparam int IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [ADDR_W-1:0] MEM_WORDS_A = ADDR_W'(MEM_WORDS);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a >> OFFS_W) < MEM_WORDS_A;
    endfunction

    function automatic logic [IDX_W-1:0] mem_idx(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] w;
        w = a >> OFFS_W;
        return w[IDX_W-1:0];
    endfunction

    logic [DATA_BYTES-1:0][7:0] mem [MEM_WORDS];

    // Holds both address channels not-ready until the first edge after reset.
    logic init_done;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) init_done <= 1'b0;
        else          init_done <= 1'b1;
    end

    // ------------------------------------------------------------------
    // Write engine
    // ------------------------------------------------------------------
    w_state_t                w_state, w_state_nx;
    logic [ADDR_W-1:0]       w_addr;
    logic [NUM_ID_BITS-1:0]  w_id;
    logic [7:0]              w_len;
    logic [1:0]              w_burst;
    logic [7:0]              w_cnt;
    logic                    w_err;
    logic [ADDR_W-1:0]       w_next_addr;
    logic                    w_last;
    logic                    w_cfg_err;
    logic                    aw_hs;
    logic                    w_hs;

    axi4_burst_addr_gen #(
        .ADDR_W     (ADDR_W),
        .DATA_BYTES (DATA_BYTES)
    ) u_wr_gen (
        .addr      (w_addr),
        .count     (w_cnt),
        .len       (w_len),
        .burst     (w_burst),
        .next_addr (w_next_addr),
        .last      (w_last),
        .err       (w_cfg_err)
    );

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign bresp = w_err ? RESP_SLVERR : RESP_OKAY;
    assign bid   = w_id;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) w_state <= W_IDLE;
        else          w_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = w_state;
        awready    = 1'b0;
        wready     = 1'b0;
        bvalid     = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = init_done;
                if (awvalid && init_done) w_state_nx = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                // Burst ends on the beat count alone, wlast is only checked.
                if (wvalid && w_last) w_state_nx = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_state_nx = W_IDLE;
            end
            default: w_state_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_addr  <= '0;
            w_id    <= '0;
            w_len   <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else if (aw_hs) begin
            w_addr  <= awaddr;
            w_id    <= awid;
            w_len   <= awlen;
            w_burst <= awburst;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else if (w_hs) begin
            w_addr <= w_next_addr;
            w_cnt  <= w_cnt + 8'd1;
            if (!in_range(w_addr) || w_cfg_err || (wlast != w_last)) begin
                w_err <= 1'b1;
            end
        end
    end

    // Memory array is intentionally not reset.
    always_ff @(posedge aclk) begin
        if (w_hs && in_range(w_addr)) begin
            for (int b = 0; b < DATA_BYTES; b++) begin
                if (wstrb[b]) mem[mem_idx(w_addr)][b] <= wdata[b*8 +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read engine
    // ------------------------------------------------------------------
    r_state_t                r_state, r_state_nx;
    logic [ADDR_W-1:0]       r_addr;
    logic [NUM_ID_BITS-1:0]  r_id;
    logic [7:0]              r_len;
    logic [1:0]              r_burst;
    logic [7:0]              r_cnt;
    logic [DATA_W-1:0]       rdata_q;
    logic [1:0]              rresp_q;
    logic                    rlast_q;
    logic [ADDR_W-1:0]       r_next_addr;
    logic                    r_last;
    logic                    r_cfg_err;
    logic                    ar_hs;
    logic                    r_hs;
    logic                    ld_en;
    logic [ADDR_W-1:0]       ld_addr;
    logic                    ld_cfg_err;

    axi4_burst_addr_gen #(
        .ADDR_W     (ADDR_W),
        .DATA_BYTES (DATA_BYTES)
    ) u_rd_gen (
        .addr      (r_addr),
        .count     (r_cnt),
        .len       (r_len),
        .burst     (r_burst),
        .next_addr (r_next_addr),
        .last      (r_last),
        .err       (r_cfg_err)
    );

    assign ar_hs = arvalid && arready;
    assign r_hs  = rvalid && rready;
    assign rdata = rdata_q;
    assign rresp = rresp_q;
    assign rid   = r_id;
    assign rlast = rlast_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= R_IDLE;
        else          r_state <= r_state_nx;
    end

    always_comb begin
        r_state_nx = r_state;
        arready    = 1'b0;
        rvalid     = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = init_done;
                if (arvalid && init_done) r_state_nx = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (rready && r_last) r_state_nx = R_IDLE;
            end
            default: r_state_nx = R_IDLE;
        endcase
    end

    // The output register is refilled on the AR handshake (first beat) and
    // on every non-final R handshake (next beat), giving back-to-back beats.
    assign ld_en      = ar_hs || (r_hs && !r_last);
    assign ld_addr    = (r_state == R_IDLE) ? araddr : r_next_addr;
    assign ld_cfg_err = (r_state == R_IDLE) ? burst_cfg_err(arlen, arburst) : r_cfg_err;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_addr  <= '0;
            r_id    <= '0;
            r_len   <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
            rlast_q <= 1'b0;
        end else if (ar_hs) begin
            r_addr  <= araddr;
            r_id    <= arid;
            r_len   <= arlen;
            r_burst <= arburst;
            r_cnt   <= '0;
            rlast_q <= (arlen == 8'd0);
        end else if (r_hs) begin
            if (r_last) begin
                rlast_q <= 1'b0;
            end else begin
                r_addr  <= r_next_addr;
                r_cnt   <= r_cnt + 8'd1;
                rlast_q <= ((r_cnt + 8'd1) == r_len);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ld_en) begin
            if (in_range(ld_addr)) begin
                rdata_q <= mem[mem_idx(ld_addr)];
                rresp_q <= ld_cfg_err ? RESP_SLVERR : RESP_OKAY;
            end else begin
                rdata_q <= '0;
                rresp_q <= RESP_SLVERR;
            end
        end
    end

endmodule

// File: tb/tb_axi4_slave_mem.sv
module tb_axi4_slave_mem;

    logic        aclk;
    logic        aresetn;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [1:0]  awburst;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    logic        rlast;

    int checks   = 0;
    int failures = 0;

    logic [31:0] wr_data [16];
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [3:0]  rd_id;

    axi4_slave_mem #(
        .DATA_BYTES  (4),
        .ADDR_BYTES  (4),
        .NUM_ID_BITS (4),
        .MEM_WORDS   (64)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .awvalid (awvalid),
        .awready (awready),
        .awaddr  (awaddr),
        .awid    (awid),
        .awlen   (awlen),
        .awburst (awburst),
        .wvalid  (wvalid),
        .wready  (wready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wlast   (wlast),
        .bvalid  (bvalid),
        .bready  (bready),
        .bresp   (bresp),
        .bid     (bid),
        .arvalid (arvalid),
        .arready (arready),
        .araddr  (araddr),
        .arid    (arid),
        .arlen   (arlen),
        .arburst (arburst),
        .rvalid  (rvalid),
        .rready  (rready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rid     (rid),
        .rlast   (rlast)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // ---------------- driver tasks (all activity at posedge + 1) --------
    task automatic do_write(input logic [31:0] addr, input logic [3:0] id,
                            input logic [7:0] len, input logic [1:0] burst,
                            input logic [3:0] strb, input int bad_last_beat,
                            output logic [1:0] resp, output logic [3:0] id_o);
        int n;
        awaddr = addr; awid = id; awlen = len; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 100) begin @(posedge aclk); #1; n++; end
        if (n >= 100) begin checks++; failures++; $display("FAIL aw_timeout got=0 want=1"); end
        @(posedge aclk); #1;
        awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            wvalid = 1'b1;
            wdata  = wr_data[b];
            wstrb  = strb;
            wlast  = (b == int'(len)) ^ (b == bad_last_beat);
            n = 0;
            while (!wready && n < 100) begin @(posedge aclk); #1; n++; end
            if (n >= 100) begin checks++; failures++; $display("FAIL w_timeout beat=%0d", b); end
            @(posedge aclk); #1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < 100) begin @(posedge aclk); #1; n++; end
        if (n >= 100) begin checks++; failures++; $display("FAIL b_timeout got=0 want=1"); end
        resp = bresp;
        id_o = bid;
        @(posedge aclk); #1;
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] id,
                           input logic [7:0] len, input logic [1:0] burst,
                           input bit toggle);
        int n;
        int k;
        araddr = addr; arid = id; arlen = len; arburst = burst; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 100) begin @(posedge aclk); #1; n++; end
        if (n >= 100) begin checks++; failures++; $display("FAIL ar_timeout got=0 want=1"); end
        @(posedge aclk); #1;
        arvalid = 1'b0;
        k = 0;
        n = 0;
        while (k <= int'(len) && n < 400) begin
            rready = toggle ? (n % 2 == 0) : 1'b1;
            if (rvalid && rready) begin
                rd_data[k] = rdata;
                rd_resp[k] = rresp;
                rd_last[k] = rlast;
                if (k == 0) rd_id = rid;
                k++;
            end
            @(posedge aclk); #1;
            n++;
        end
        rready = 1'b0;
        if (k <= int'(len)) begin
            checks++; failures++;
            $display("FAIL r_timeout beats=%0d want=%0d", k, int'(len) + 1);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        aresetn = 1'b0;
        awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awburst = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
        arvalid = 0; araddr = 0; arid = 0; arlen = 0; arburst = 0; rready = 0;
        #2;
        checks++;
        if ({awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp} !== 10'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=0",
                     {awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp});
        end
        repeat (3) @(posedge aclk);
        #3 aresetn = 1'b1;
        #1;
        checks++;
        if (awready !== 1'b0 || arready !== 1'b0) begin
            failures++; $display("FAIL ready_before_edge got=%b%b want=00", awready, arready);
        end
        @(posedge aclk); #1;
        checks++;
        if (awready !== 1'b1 || arready !== 1'b1) begin
            failures++; $display("FAIL ready_after_edge got=%b%b want=11", awready, arready);
        end
    endtask

    task automatic test_incr();
        logic [1:0] resp;
        logic [3:0] id_o;
        for (int i = 0; i < 4; i++) wr_data[i] = 32'(i + 1);
        do_write(32'h10, 4'd5, 8'd3, 2'b01, 4'hF, -1, resp, id_o);
        checks++;
        if (resp !== 2'b00 || id_o !== 4'd5) begin
            failures++; $display("FAIL incr_bresp got=%h/%h want=0/5", resp, id_o);
        end
        do_read(32'h10, 4'd9, 8'd3, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_data[i] !== 32'(i + 1) || rd_resp[i] !== 2'b00 || rd_last[i] !== (i == 3)) begin
                failures++;
                $display("FAIL incr_read beat=%0d got=%h/%h/%b want=%h/0/%b",
                         i, rd_data[i], rd_resp[i], rd_last[i], i + 1, i == 3);
            end
        end
        checks++;
        if (rd_id !== 4'd9) begin failures++; $display("FAIL incr_rid got=%h want=9", rd_id); end
        checks++;
        if (rvalid !== 1'b0) begin failures++; $display("FAIL rvalid_after_burst got=1 want=0"); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_d [4];
        exp_d[0] = 32'd3; exp_d[1] = 32'd4; exp_d[2] = 32'd1; exp_d[3] = 32'd2;
        do_read(32'h18, 4'd1, 8'd3, 2'b10, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_data[i] !== exp_d[i] || rd_resp[i] !== 2'b00) begin
                failures++;
                $display("FAIL wrap_read beat=%0d got=%h/%h want=%h/0", i, rd_data[i], rd_resp[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_strobe_fixed();
        logic [1:0] resp;
        logic [3:0] id_o;
        wr_data[0] = 32'hFFFF_FFFF;
        do_write(32'h20, 4'd1, 8'd0, 2'b01, 4'hF, -1, resp, id_o);
        wr_data[0] = 32'h0000_1234;
        do_write(32'h20, 4'd1, 8'd0, 2'b01, 4'h3, -1, resp, id_o);
        do_read(32'h20, 4'd2, 8'd0, 2'b01, 1'b0);
        checks++;
        if (rd_data[0] !== 32'hFFFF_1234) begin
            failures++; $display("FAIL strobe_merge got=%h want=ffff1234", rd_data[0]);
        end
        wr_data[0] = 32'hA; wr_data[1] = 32'hB; wr_data[2] = 32'hC;
        do_write(32'h24, 4'd3, 8'd2, 2'b00, 4'hF, -1, resp, id_o);
        checks++;
        if (resp !== 2'b00 || id_o !== 4'd3) begin
            failures++; $display("FAIL fixed_bresp got=%h/%h want=0/3", resp, id_o);
        end
        do_read(32'h24, 4'd2, 8'd0, 2'b01, 1'b0);
        checks++;
        if (rd_data[0] !== 32'hC) begin failures++; $display("FAIL fixed_final got=%h want=c", rd_data[0]); end
    endtask

    task automatic test_errors();
        logic [1:0] resp;
        logic [3:0] id_o;
        wr_data[0] = 32'h5A5A_5A5A;
        do_write(32'h00, 4'd0, 8'd0, 2'b01, 4'hF, -1, resp, id_o);
        wr_data[0] = 32'hDEAD_BEEF;
        do_write(32'h100, 4'd7, 8'd0, 2'b01, 4'hF, -1, resp, id_o);
        checks++;
        if (resp !== 2'b10 || id_o !== 4'd7) begin
            failures++; $display("FAIL oor_write_bresp got=%h/%h want=2/7", resp, id_o);
        end
        do_read(32'h00, 4'd0, 8'd0, 2'b01, 1'b0);
        checks++;
        if (rd_data[0] !== 32'h5A5A_5A5A) begin
            failures++; $display("FAIL oor_no_alias got=%h want=5a5a5a5a", rd_data[0]);
        end
        wr_data[0] = 32'h62; wr_data[1] = 32'h63;
        do_write(32'hF8, 4'd0, 8'd1, 2'b01, 4'hF, -1, resp, id_o);
        checks++;
        if (resp !== 2'b00) begin failures++; $display("FAIL edge_write_bresp got=%h want=0", resp); end
        do_read(32'hF8, 4'd4, 8'd3, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_data[i] !== ((i < 2) ? 32'(32'h62 + i) : 32'h0) ||
                rd_resp[i] !== ((i < 2) ? 2'b00 : 2'b10)) begin
                failures++;
                $display("FAIL oor_read beat=%0d got=%h/%h", i, rd_data[i], rd_resp[i]);
            end
        end
        wr_data[0] = 32'h1; wr_data[1] = 32'h2;
        do_write(32'h28, 4'd0, 8'd1, 2'b01, 4'hF, 0, resp, id_o);
        checks++;
        if (resp !== 2'b10) begin failures++; $display("FAIL wlast_err got=%h want=2", resp); end
        wr_data[2] = 32'h3;
        do_write(32'h28, 4'd0, 8'd2, 2'b10, 4'hF, -1, resp, id_o);
        checks++;
        if (resp !== 2'b10) begin failures++; $display("FAIL wrap_len_err got=%h want=2", resp); end
        do_read(32'h10, 4'd0, 8'd1, 2'b11, 1'b0);
        checks++;
        if (rd_resp[0] !== 2'b10 || rd_resp[1] !== 2'b10) begin
            failures++; $display("FAIL rsvd_read got=%h/%h want=2/2", rd_resp[0], rd_resp[1]);
        end
    endtask

    task automatic test_concurrent();
        logic [1:0] resp;
        logic [3:0] id_o;
        for (int i = 0; i < 4; i++) wr_data[i] = 32'(32'h11 + i);
        fork
            do_write(32'h30, 4'd2, 8'd3, 2'b01, 4'hF, -1, resp, id_o);
            do_read(32'h10, 4'd6, 8'd3, 2'b01, 1'b1);
        join
        checks++;
        if (resp !== 2'b00 || id_o !== 4'd2) begin
            failures++; $display("FAIL conc_bresp got=%h/%h want=0/2", resp, id_o);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_data[i] !== 32'(i + 1) || rd_last[i] !== (i == 3)) begin
                failures++; $display("FAIL conc_read beat=%0d got=%h want=%h", i, rd_data[i], i + 1);
            end
        end
        do_read(32'h30, 4'd6, 8'd3, 2'b01, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_data[i] !== 32'(32'h11 + i)) begin
                failures++; $display("FAIL conc_readback beat=%0d got=%h want=%h", i, rd_data[i], 32'h11 + i);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int n;
        araddr = 32'h10; arid = 4'd3; arlen = 8'd0; arburst = 2'b01; arvalid = 1'b1; rready = 1'b0;
        n = 0;
        while (!arready && n < 100) begin @(posedge aclk); #1; n++; end
        @(posedge aclk); #1;
        arvalid = 1'b0;
        checks++;
        if (rvalid !== 1'b1 || rlast !== 1'b1 || rid !== 4'd3) begin
            failures++; $display("FAIL pre_reset got=%b/%b/%h want=1/1/3", rvalid, rlast, rid);
        end
        #2 aresetn = 1'b0;
        #1;
        checks++;
        if (rvalid !== 1'b0 || rlast !== 1'b0 || arready !== 1'b0) begin
            failures++; $display("FAIL mid_reset got=%b/%b/%b want=0/0/0", rvalid, rlast, arready);
        end
        @(posedge aclk);
        #3 aresetn = 1'b1;
        #1;
        checks++;
        if (arready !== 1'b0) begin failures++; $display("FAIL arready_early got=1 want=0"); end
        @(posedge aclk); #1;
        checks++;
        if (arready !== 1'b1) begin failures++; $display("FAIL arready_release got=0 want=1"); end
        do_read(32'h10, 4'd3, 8'd0, 2'b01, 1'b0);
        checks++;
        if (rd_data[0] !== 32'd1) begin failures++; $display("FAIL mem_retained got=%h want=1", rd_data[0]); end
    endtask

    initial begin
        test_reset();
        test_incr();
        test_wrap();
        test_strobe_fixed();
        test_errors();
        test_concurrent();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi4_slave_mem.md
Name:
axi4_slave_mem

Overview:
Parametrised synthesizable AXI4 slave memory. It supports FIXED, INCR and WRAP bursts up to 256 beats, byte strobes, ID echo and SLVERR on out-of-range accesses. It is the next-generation endpoint for axi4_if based benches and SoC sims, and replaces behavioural slave BFMs where a cycle-accurate, synthesizable target is needed. Independent read and write engines run concurrently, with one outstanding transaction per direction.

Parameters:
DATA_BYTES, 4, data bus width in bytes (power of 2)
ADDR_BYTES, 4, address width in bytes
NUM_ID_BITS, 4, AxID/xID width
MEM_WORDS, 1024, memory depth in DATA_BYTES-wide words

Ports:
aclk in 1 clock
aresetn in 1 async active-low reset
awvalid in 1 write address valid
awready out 1 write address ready
awaddr in ADDR_BYTES*8 byte address
awid in NUM_ID_BITS write ID
awlen in 8 beats-1
awburst in 2 burst type
wvalid in 1 write data valid
wready out 1 write data ready
wdata in DATA_BYTES*8 write data
wstrb in DATA_BYTES byte enables
wlast in 1 last write beat
bvalid out 1 response valid
bready in 1 response ready
bresp out 2 write response
bid out NUM_ID_BITS echoed awid
arvalid in 1 read address valid
arready out 1 read address ready
araddr in ADDR_BYTES*8 byte address
arid in NUM_ID_BITS read ID
arlen in 8 beats-1
arburst in 2 burst type
rvalid out 1 read data valid
rready in 1 read data ready
rdata out DATA_BYTES*8 read data
rresp out 2 read response
rid out NUM_ID_BITS echoed arid
rlast out 1 last read beat

Behaviour:
- Clock aclk; reset aresetn, asynchronous, active-low. On reset all outputs are 0, including awready and arready; both engines go to IDLE. awready and arready rise on the first edge after reset release. Memory contents are not reset.
- Addressing: word index = addr >> log2(DATA_BYTES); low address bits are ignored; all beats are full width.
- Write FSM W_IDLE→W_DATA→W_RESP:
  - W_IDLE: awready=1. On AW handshake, latch addr/id/len/burst, clear beat count, go to W_DATA (awready=0, wready=1).
  - W_DATA: each W handshake writes the bytes enabled by wstrb, then advances address and count.
  - After the beat with count==len, go to W_RESP (wready=0, bvalid=1, bid=latched id).
  - W_RESP: hold bvalid, bresp and bid until bready; then return to W_IDLE.
- Read FSM R_IDLE→R_DATA:
  - R_IDLE: arready=1. On AR handshake, latch fields; on the next cycle rvalid=1 with rdata registered from the first address.
  - R_DATA: on each R handshake, load the next beat in the same edge, so beats are back-to-back while rready stays high. rlast=1 on beat count==len.
  - After the last handshake, rvalid=0 and return to R_IDLE.
  - With rvalid high and rready low, rdata/rresp/rid/rlast stay stable.
- Burst address update:
  - FIXED (00): address held.
  - INCR (01): +DATA_BYTES per beat.
  - WRAP (10): wraps at a (len+1)*DATA_BYTES aligned boundary.
  - WRAP with len not in {1,3,7,15}, or reserved burst 11: treated as INCR with SLVERR.
- Errors:
  - Write: any beat at word index ≥ MEM_WORDS is not written, and that burst gets bresp=SLVERR (2'b10).
  - Read: such a beat returns rdata=0 with rresp=SLVERR for that beat only.
  - wlast asserted at count≠len, or deasserted at count==len: bresp=SLVERR. Termination is by count only.
- Simultaneous read and write of the same word in one edge: the read returns the old value.
- Reset during a burst aborts it. Beats already written remain in memory.

Decomposition:
- Package axi4_pkg: burst_t (FIXED/INCR/WRAP/RSVD), resp_t (OKAY=0, SLVERR=2), function wrap_mask(len, DATA_BYTES).
- Sub-module axi4_burst_addr_gen (start addr, len, burst, step → next addr, last, err), instantiated once for write and once for read.

Test Plan:
- DATA_BYTES=4, MEM_WORDS=64. INCR write awaddr 0x10, awlen 3, awid 5, data 1..4, wstrb F → bresp 0, bid 5. INCR read 0x10, len 3, arid 9 → rdata 1,2,3,4, rlast only on the 4th beat, rid 9.
- After test 1, WRAP read araddr 0x18, len 3 → beat addresses 0x18,0x1C,0x10,0x14, rdata 3,4,1,2.
- Word 0x20 preloaded 0xFFFFFFFF; write 0x20 with wstrb 0x3, data 0x00001234 → reads back 0xFFFF1234. FIXED write 0x24, len 2, data A,B,C → read 0x24 returns C.
- Write awaddr 0x100 (word 64) → bresp 2'b10, memory unchanged. INCR read 0xF8, len 3 → beats 0,1 rresp 0; beats 2,3 rdata 0, rresp 2'b10.
- Concurrent AW and AR with rready toggling every cycle → beat order and values intact, no drops. Assert aresetn low mid read burst → rvalid and rlast drop immediately; arready=1 one edge after release.
